// File: rtl/ghost_move_checker.sv
// ghost_move_checker: reads the four neighbour tiles of a ghost's tile from the
// maze ROM (one read per cycle, 1-cycle ROM latency), resolves tunnel wrap,
// edge rows and door rules, and publishes registered passability flags with a
// one-cycle valid pulse.
module ghost_move_checker #(
   parameter int MAZE_W = 28,
   parameter int MAZE_H = 36,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [5:0]        ghostX,
   input  logic [5:0]        ghostY,
   input  logic              allowDoor,
   output logic [ADDR_W-1:0] romAddr,
   input  logic [1:0]        romData,
   output logic              busy,
   output logic              valid,
   output logic              canMoveUp,
   output logic              canMoveRight,
   output logic              canMoveDown,
   output logic              canMoveLeft
);

   localparam logic [5:0] XMAX = 6'(MAZE_W - 1);
   localparam logic [5:0] YMAX = 6'(MAZE_H - 1);

   typedef enum logic [2:0] {
      IDLE, RD_UP, RD_RIGHT, RD_DOWN, RD_LEFT, FINISH
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  x_q, y_q;
   logic        door_q;
   logic        up_q, right_q, down_q;
   logic [3:0]  flags_q;   // {up, right, down, left}
   logic        valid_q;

   logic        illegal;
   logic        tile_pass;
   logic [5:0]  x_right, x_left;
   logic [5:0]  nx, ny;
   logic        addr_en;
   logic [ADDR_W-1:0] yw, xw;

   assign illegal   = (x_q > XMAX) || (y_q > YMAX);
   assign x_right   = (x_q == XMAX) ? 6'd0 : x_q + 6'd1;
   assign x_left    = (x_q == 6'd0) ? XMAX : x_q - 6'd1;
   // door tiles pass only with the door permission latched at start
   assign tile_pass = (romData == 2'd0) || (romData == 2'd3) ||
                      ((romData == 2'd2) && door_q);

   // Neighbour coordinate for the slot being driven; edge-row slots that are
   // forced blocked drive address 0 so the address never leaves the maze.
   always_comb begin
      nx      = x_q;
      ny      = y_q;
      addr_en = 1'b0;
      unique case (state_q)
         RD_UP: begin
            ny      = y_q - 6'd1;
            addr_en = (y_q != 6'd0);
         end
         RD_RIGHT: begin
            nx      = x_right;
            addr_en = 1'b1;
         end
         RD_DOWN: begin
            ny      = y_q + 6'd1;
            addr_en = (y_q != YMAX);
         end
         RD_LEFT: begin
            nx      = x_left;
            addr_en = 1'b1;
         end
         default: addr_en = 1'b0;
      endcase
   end

   // Y*28 + X without a multiplier
   assign yw      = ADDR_W'(ny);
   assign xw      = ADDR_W'(nx);
   assign romAddr = (addr_en && !illegal) ? ((yw << 5) - (yw << 2) + xw)
                                          : '0;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state: fixed five-slot schedule once a start is accepted
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (start) state_d = RD_UP;
         RD_UP:    state_d = RD_RIGHT;
         RD_RIGHT: state_d = RD_DOWN;
         RD_DOWN:  state_d = RD_LEFT;
         RD_LEFT:  state_d = FINISH;
         FINISH:   state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Latch request, capture each ROM result one state after its address,
   // and load all four flags together on leaving FINISH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q     <= '0;
         y_q     <= '0;
         door_q  <= 1'b0;
         up_q    <= 1'b0;
         right_q <= 1'b0;
         down_q  <= 1'b0;
         flags_q <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            IDLE: if (start) begin
               x_q    <= ghostX;
               y_q    <= ghostY;
               door_q <= allowDoor;
            end
            RD_RIGHT: up_q    <= (y_q != 6'd0) && tile_pass;
            RD_DOWN:  right_q <= tile_pass;
            RD_LEFT:  down_q  <= (y_q != YMAX) && tile_pass;
            FINISH: begin
               flags_q <= illegal ? 4'b0000 : {up_q, right_q, down_q, tile_pass};
               valid_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy         = (state_q != IDLE);
   assign valid        = valid_q;
   assign canMoveUp    = flags_q[3];
   assign canMoveRight = flags_q[2];
   assign canMoveDown  = flags_q[1];
   assign canMoveLeft  = flags_q[0];

endmodule

// File: doc/ghost_move_checker.md
# ghost_move_checker

Sequential maze-lookup stage that sits directly upstream of the ghost movement controllers. Given a ghost's current tile, it reads the four neighbouring tiles from the shared maze tile ROM, one per cycle. It then publishes registered `canMoveUp`/`canMoveRight`/`canMoveDown`/`canMoveLeft` flags with a one-cycle `valid` pulse, which the ghost FSM consumes on its next step decision. Tunnel wrap-around and ghost-house door rules are resolved here, not in the ghost.

## Interface
Parameters:
- `MAZE_W`, 28, maze width in tiles.
- `MAZE_H`, 36, maze height in tiles.
- `ADDR_W`, 10, ROM address width.

Ports:
- `clk`  input  1  system clock (25 MHz).
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a lookup. Sampled only while `busy`=0.
- `ghostX`  input  6  ghost tile X. Latched on accepted `start`.
- `ghostY`  input  6  ghost tile Y. Latched on accepted `start`.
- `allowDoor`  input  1  door tiles are passable. Latched on accepted `start`.
- `romAddr`  output  ADDR_W  maze ROM address, combinational from state and latched coordinates.
- `romData`  input  2  tile code, valid one cycle after `romAddr`. Codes: 0 = path, 1 = wall, 2 = ghost door, 3 = tunnel path.
- `busy`  output  1  lookup in progress.
- `valid`  output  1  one-cycle pulse; the flags were updated on the same edge.
- `canMoveUp`, `canMoveRight`, `canMoveDown`, `canMoveLeft`  output  1 each  registered passability flags.

## Operation
- States: IDLE, RD_UP, RD_RIGHT, RD_DOWN, RD_LEFT, FINISH.
- IDLE: `start`=1 latches `ghostX`, `ghostY` and `allowDoor`, then moves to RD_UP. `busy` goes high on the same edge.
- RD_UP: drive the up-neighbour address, then go to RD_RIGHT.
- RD_RIGHT: drive the right-neighbour address and capture the up result, then go to RD_DOWN.
- RD_DOWN: drive the down-neighbour address and capture the right result, then go to RD_LEFT.
- RD_LEFT: drive the left-neighbour address and capture the down result, then go to FINISH.
- FINISH: capture the left result and load all four output flags together. Assert `valid` and clear `busy`, then return to IDLE.
- Neighbour coordinates:
  - Up = (X, Y-1); down = (X, Y+1).
  - Left = (X-1, Y), except X=0 gives (27, Y).
  - Right = (X+1, Y), except X=27 gives (0, Y).
- Address = Y*28 + X, computed as (Y<<5) - (Y<<2) + X in ADDR_W bits. Maximum address is 1007; no overflow.
- Passability per tile code:
  - Code 0 or 3: passable.
  - Code 1: blocked.
  - Code 2: passable only when latched `allowDoor`=1.
- Edge rows:
  - Y=0: up is forced 0, regardless of `romData`.
  - Y=35: down is forced 0.
  - The ROM slot is still consumed in both cases, so the schedule is fixed.
- Illegal position (latched X>27 or Y>35): all four flags are 0. The sequence runs normally and `valid` still pulses. `romAddr` is clamped to 0 in that case.
- Outputs change only in FINISH, all four flags together. Between updates they hold their last values.

## Timing
- Reset (async assert, or `reset_n` low mid-lookup):
  - State returns to IDLE.
  - `busy`=0, `valid`=0, all `canMove*`=0, `romAddr`=0.
  - Any in-flight lookup is discarded; there is no `valid` for it.
- Latency: `start` sampled at edge E0 gives `valid`=1 in the cycle after edge E5. Flags are stable from E5.
- `busy`=1 for exactly 5 cycles (after E0 through E5). `valid` is high for exactly 1 cycle.
- `start` while `busy`=1 is ignored and not queued.
- `start`=1 in the `valid` cycle is accepted, giving back-to-back lookups every 6 cycles.
- Holding `start` high permanently gives one lookup per 6 cycles.
- ROM read latency is exactly 1 cycle. Data for the address driven in state S is captured on the edge leaving the following state.

## Test plan
- **Open crossing.** Reset release; ROM has a cross of code 0 around (6,4); `start` with X=6, Y=4. Required: `romAddr` sequence 90, 119, 146, 117 in RD_UP..RD_LEFT; `valid` 6 cycles after `start`; all four flags 1.
- **Tunnel wrap.** X=27, Y=19, row 19 all code 3. Required: right address 532 (X=0) and left address 558; right=1, left=1; up/down follow the ROM.
- **Ghost door.** X=13, Y=17; tile (13,16) is code 2.
  - With `allowDoor`=0: up=0.
  - Repeat with `allowDoor`=1: up=1.
  - Toggling `allowDoor` mid-lookup changes nothing.
- **Edges and illegal input.**
  - Y=0 with ROM path above: up=0.
  - X=40: all flags 0; `valid` still pulses at the same latency.
- **Handshake.**
  - `start` re-asserted while `busy`: ignored, exactly one `valid`.
  - `start` held high: `valid` every 6 cycles; flags stay stable between pulses.
- **Reset mid-operation.** Drop `reset_n` in RD_DOWN. Required: immediate `busy`=0 and flags 0; no `valid`; the next `start` completes normally.
